rmii_mii_bridge_ce: RTL and testbench

//  Single-clock bidirectional RMII<->MII bridge for the UDP datapath. It runs

---
 rtl/rmii_mii_bridge_ce.sv | 146 ++++++++++++++
 tb/tb_rmii_mii_bridge_ce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rmii_mii_bridge_ce.sv
// rmii_mii_bridge_ce: single-clock RMII<->MII bridge on the 50 MHz reference clock,
// with nibble-rate enable, preamble alignment, odd-dibit detection and TX IPG policing.
module rmii_mii_bridge_ce #(
  parameter bit SPEED_100  = 1'b1,
  parameter int TX_IPG_NIB = 24
) (
  input  logic        eth_clk,
  input  logic        sys_rst_n,
  output logic        mii_ce,
  input  logic        rmii_rx_dv,
  input  logic [1:0]  rmii_rx_data,
  output logic        mii_rx_dv,
  output logic [3:0]  mii_rx_data,
  output logic        rx_err,
  output logic [15:0] rx_frame_cnt,
  input  logic        mii_tx_en,
  input  logic [3:0]  mii_tx_data,
  output logic        rmii_tx_en,
  output logic [1:0]  rmii_tx_data,
  output logic        tx_busy,
  output logic        tx_ipg_viol
);
  localparam int GW = $clog2(TX_IPG_NIB + 1);
  typedef enum logic [1:0] {IDLE, PRE, DATA} rx_st_e;
  rx_st_e st_q, st_d;
  logic [3:0] div_q, div_d;
  logic ph_q, ph_d, stb;
  logic [1:0] lo_q, lo_d;
  logic odd_q, odd_d, rdv_q, rdv_d, err_q, err_d;
  logic [3:0] rdat_q, rdat_d;
  logic [15:0] cnt_q, cnt_d;
  logic en_q, en_d, sup_q, sup_d, ten_q, ten_d, viol_q, viol_d;
  logic [1:0] hi_q, hi_d, tdat_q, tdat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic rise, fall, viol, sup_nx, send;
  assign stb    = SPEED_100 ? 1'b1 : (div_q == 4'd9);
  assign div_d  = (SPEED_100 || div_q == 4'd9) ? 4'd0 : div_q + 4'd1;
  assign ph_d   = ph_q ^ stb;
  assign mii_ce = stb & ph_q;
  always_comb begin
    st_d = st_q;
    lo_d = lo_q;
    odd_d = odd_q;
    rdv_d = rdv_q;
    rdat_d = rdat_q;
    err_d = 1'b0;
    cnt_d = cnt_q;
    if (stb)
      case (st_q)
        IDLE: st_d = rmii_rx_dv ? PRE : IDLE;
        PRE: begin
          st_d = !rmii_rx_dv ? IDLE : (rmii_rx_data == 2'b01) ? DATA : PRE;
          lo_d = rmii_rx_data;
          odd_d = 1'b1;
        end
        DATA: begin
          // An odd ending drops the partial nibble; the last full nibble has then
          // already been shown for a whole nibble period, so valid drops here too.
          if (!rmii_rx_dv) begin
            st_d = IDLE;
            rdv_d = 1'b0;
            err_d = odd_q;
            cnt_d = cnt_q + 16'd1;
          end else if (odd_q) begin
            rdat_d = {rmii_rx_data, lo_q};
            rdv_d = 1'b1;
            odd_d = 1'b0;
          end else begin
            lo_d = rmii_rx_data;
            odd_d = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
  end
  assign rise   = mii_tx_en & ~en_q;
  assign fall   = ~mii_tx_en & en_q;
  assign viol   = rise & (gap_q != '0);
  assign sup_nx = viol | (sup_q & mii_tx_en);
  assign send   = mii_tx_en & ~sup_nx;
  always_comb begin
    en_d = en_q;
    sup_d = sup_q;
    ten_d = ten_q;
    tdat_d = tdat_q;
    hi_d = hi_q;
    gap_d = gap_q;
    viol_d = 1'b0;
    // The nibble on which enable falls is the first idle nibble of the gap.
    if (mii_ce) begin
      en_d = mii_tx_en;
      sup_d = sup_nx;
      ten_d = send;
      tdat_d = send ? mii_tx_data[1:0] : 2'b00;
      hi_d = send ? mii_tx_data[3:2] : 2'b00;
      viol_d = viol;
      gap_d = fall ? GW'(TX_IPG_NIB - 1) : (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    end else if (stb) begin
      tdat_d = hi_q;
    end
  end
  always_ff @(posedge eth_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      st_q <= IDLE;
      div_q <= '0;
      ph_q <= 1'b0;
      lo_q <= '0;
      odd_q <= 1'b0;
      rdv_q <= 1'b0;
      rdat_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      en_q <= 1'b0;
      sup_q <= 1'b0;
      ten_q <= 1'b0;
      tdat_q <= '0;
      hi_q <= '0;
      gap_q <= '0;
      viol_q <= 1'b0;
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      ph_q <= ph_d;
      lo_q <= lo_d;
      odd_q <= odd_d;
      rdv_q <= rdv_d;
      rdat_q <= rdat_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      sup_q <= sup_d;
      ten_q <= ten_d;
      tdat_q <= tdat_d;
      hi_q <= hi_d;
      gap_q <= gap_d;
      viol_q <= viol_d;
    end
  assign mii_rx_dv    = rdv_q;
  assign mii_rx_data  = rdat_q;
  assign rx_err       = err_q;
  assign rx_frame_cnt = cnt_q;
  assign rmii_tx_en   = ten_q;
  assign rmii_tx_data = tdat_q;
  assign tx_busy      = en_q | (gap_q != '0);
  assign tx_ipg_viol  = viol_q;
endmodule

// File: tb/tb_rmii_mii_bridge_ce.sv
// tb_rmii_mii_bridge_ce: scoreboard bench driving a 100 Mb/s and a 10 Mb/s bridge
// with directed RMII frames and MII nibbles; monitors pop expected nibbles/dibits.
module tb_rmii_mii_bridge_ce;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;
  logic r1_dv, r0_dv, t1_en, t0_en;
  logic [1:0] r1_d, r0_d, td1, td0;
  logic [3:0] t1_d, t0_d, mr1_d, mr0_d;
  logic ce1, ce0, mr1_dv, mr0_dv, er1, er0, te1, te0, bz1, bz0, vi1, vi0;
  logic [15:0] fc1, fc0;

  rmii_mii_bridge_ce #(.SPEED_100(1'b1), .TX_IPG_NIB(24)) u100 (
    .eth_clk(clk), .sys_rst_n(rst_n), .mii_ce(ce1),
    .rmii_rx_dv(r1_dv), .rmii_rx_data(r1_d), .mii_rx_dv(mr1_dv), .mii_rx_data(mr1_d),
    .rx_err(er1), .rx_frame_cnt(fc1), .mii_tx_en(t1_en), .mii_tx_data(t1_d),
    .rmii_tx_en(te1), .rmii_tx_data(td1), .tx_busy(bz1), .tx_ipg_viol(vi1));
  rmii_mii_bridge_ce #(.SPEED_100(1'b0), .TX_IPG_NIB(24)) u10 (
    .eth_clk(clk), .sys_rst_n(rst_n), .mii_ce(ce0),
    .rmii_rx_dv(r0_dv), .rmii_rx_data(r0_d), .mii_rx_dv(mr0_dv), .mii_rx_data(mr0_d),
    .rx_err(er0), .rx_frame_cnt(fc0), .mii_tx_en(t0_en), .mii_tx_data(t0_d),
    .rmii_tx_en(te0), .rmii_tx_data(td0), .tx_busy(bz0), .tx_ipg_viol(vi0));

  typedef struct {int c; logic [1:0] d;} tx_t;
  tx_t txq1[$], txq0[$];
  logic [3:0] rxq1[$], rxq0[$];
  logic [7:0] frm [10];
  int vectors = 0, miscompares = 0, cyc = 0;
  int e1 = 0, e0 = 0, v1 = 0, m1_cnt = 0, m0_cnt = 0;
  bit m1_en = 1'b1;
  logic m1_prev = 1'b0, m0_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    tx_t t;
    #1;
    if (er1) e1++;
    if (er0) e0++;
    if (vi1) v1++;
    if (m1_en && mr1_dv && (!m1_prev || m1_cnt == 1)) begin
      m1_cnt = 0;
      chk("rx100 nibble expected", rxq1.size() > 0, 1);
      if (rxq1.size() > 0) chk("rx100 nibble", mr1_d, rxq1.pop_front());
    end else m1_cnt++;
    m1_prev = mr1_dv;
    if (mr0_dv && (!m0_prev || m0_cnt == 19)) begin
      m0_cnt = 0;
      chk("rx10 nibble expected", rxq0.size() > 0, 1);
      if (rxq0.size() > 0) chk("rx10 nibble", mr0_d, rxq0.pop_front());
    end else m0_cnt++;
    m0_prev = mr0_dv;
    if (te1) begin
      chk("tx100 dibit expected", txq1.size() > 0, 1);
      if (txq1.size() > 0) begin
        t = txq1.pop_front();
        chk("tx100 {cycle,dibit}", {cyc[29:0], td1}, {t.c[29:0], t.d});
      end
    end
    if (te0) begin
      chk("tx10 dibit expected", txq0.size() > 0, 1);
      if (txq0.size() > 0) begin
        t = txq0.pop_front();
        chk("tx10 {cycle,dibit}", {cyc[29:0], td0}, {t.c[29:0], t.d});
      end
    end
  end

  task automatic rx_dib(input bit sp, input logic dv, input logic [1:0] d);
    if (sp) begin r1_dv = dv; r1_d = d; end
    else begin r0_dv = dv; r0_d = d; end
    repeat (sp ? 1 : 10) @(negedge clk);
  endtask

  task automatic rx_frame(input bit sp, input bit odd, input int nb, input bit push);
    rx_dib(sp, 1'b1, 2'b00);
    rx_dib(sp, 1'b1, 2'b00);
    for (int i = 0; i < nb; i++) begin
      if (push && sp) begin rxq1.push_back(frm[i][3:0]); rxq1.push_back(frm[i][7:4]); end
      if (push && !sp) begin rxq0.push_back(frm[i][3:0]); rxq0.push_back(frm[i][7:4]); end
      for (int j = 0; j < 4; j++) rx_dib(sp, 1'b1, frm[i][2*j +: 2]);
    end
    if (nb < 10) return;
    if (odd) rx_dib(sp, 1'b1, 2'b10);
    for (int j = 0; j < 4; j++) rx_dib(sp, 1'b0, 2'b00);
  endtask

  task automatic tx_nib(input bit sp, input logic en, input logic [3:0] d, input bit push);
    int n = 0;
    tx_t t;
    do begin @(negedge clk); n++; end while (!(sp ? ce1 : ce0) && n < 50);
    chk("tx mii_ce seen", sp ? ce1 : ce0, 1);
    if (sp) begin t1_en = en; t1_d = d; end
    else begin t0_en = en; t0_d = d; end
    if (push)
      for (int k = 0; k < (sp ? 2 : 20); k++) begin
        t.c = cyc + 1 + k;
        t.d = (k < (sp ? 1 : 10)) ? d[1:0] : d[3:2];
        if (sp) txq1.push_back(t); else txq0.push_back(t);
      end
  endtask

  initial begin
    int n, eb;
    frm = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12, 8'h34};
    rst_n = 1'b0;
    {r1_dv, r0_dv, t1_en, t0_en} = '0;
    {r1_d, r0_d, t1_d, t0_d} = '0;
    repeat (3) @(negedge clk);
    chk("rst mii_ce100", ce1, 0);
    chk("rst mii_rx_dv100", mr1_dv, 0);
    chk("rst mii_rx_data100", mr1_d, 0);
    chk("rst frame_cnt100", fc1, 0);
    chk("rst rmii_tx_en100", te1, 0);
    chk("rst tx_busy100", bz1, 0);
    chk("rst mii_ce10", ce0, 0);
    chk("rst frame_cnt10", fc0, 0);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin @(negedge clk); n += int'(ce1); end
    chk("mii_ce100 pulses per 40 cycles", n, 20);
    n = 0;
    repeat (200) begin @(negedge clk); n += int'(ce0); end
    chk("mii_ce10 pulses per 200 cycles", n, 10);

    rx_frame(1'b1, 1'b0, 10, 1'b1);
    chk("rx100 leftover nibbles", rxq1.size(), 0);
    chk("rx100 frame_cnt", fc1, 1);
    chk("rx100 rx_err pulses", e1, 0);
    rx_frame(1'b1, 1'b1, 10, 1'b1);
    chk("rx100 odd leftover nibbles", rxq1.size(), 0);
    chk("rx100 odd frame_cnt", fc1, 2);
    chk("rx100 odd rx_err pulses", e1, 1);

    tx_nib(1'b1, 1'b1, 4'h5, 1'b1);
    tx_nib(1'b1, 1'b1, 4'hD, 1'b1);
    tx_nib(1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("tx100 idle dibit", td1, 0);
    chk("tx100 busy in gap", bz1, 1);
    repeat (9) tx_nib(1'b1, 1'b0, 4'h0, 1'b0);
    tx_nib(1'b1, 1'b1, 4'h5, 1'b0);
    tx_nib(1'b1, 1'b1, 4'hD, 1'b0);
    repeat (23) tx_nib(1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("tx100 busy after 23 idle", bz1, 1);
    tx_nib(1'b1, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("tx100 busy after 24 idle", bz1, 0);
    tx_nib(1'b1, 1'b1, 4'h3, 1'b1);
    tx_nib(1'b1, 1'b1, 4'hA, 1'b1);
    tx_nib(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("tx100 leftover dibits", txq1.size(), 0);
    chk("tx100 ipg_viol pulses", v1, 1);

    rx_frame(1'b0, 1'b0, 10, 1'b1);
    chk("rx10 leftover nibbles", rxq0.size(), 0);
    chk("rx10 frame_cnt", fc0, 1);
    chk("rx10 rx_err pulses", e0, 0);
    tx_nib(1'b0, 1'b1, 4'h5, 1'b1);
    tx_nib(1'b0, 1'b1, 4'hD, 1'b1);
    tx_nib(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (25) @(negedge clk);
    chk("tx10 leftover dibits", txq0.size(), 0);

    m1_en = 1'b0;
    rx_frame(1'b1, 1'b0, 4, 1'b0);
    chk("pre-reset mii_rx_dv100", mr1_dv, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst mii_rx_dv100", mr1_dv, 0);
    chk("midrst mii_rx_data100", mr1_d, 0);
    chk("midrst frame_cnt100", fc1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r1_dv = 1'b0;
    r1_d = 2'b00;
    repeat (4) @(negedge clk);
    m1_prev = 1'b0;
    m1_en = 1'b1;
    eb = e1;
    rx_frame(1'b1, 1'b0, 10, 1'b1);
    chk("post-reset leftover nibbles", rxq1.size(), 0);
    chk("post-reset frame_cnt100", fc1, 1);
    chk("post-reset rx_err pulses", e1 - eb, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
